// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew
// Receive side of the systolic skew protocol. Lane i of the array output
// carries row element k at cycle t0+k+i. Each lane is delayed by
// SA_LENGTH-1-i stages plus one common output register, so the whole row
// appears on Outputs at t0+k+SA_LENGTH with Out_Valid set.
//
// The block also reports which row of the SA_LENGTH-row tile is on Outputs
// (Row_Count) and pulses Tile_Done with the last row of each tile.
//
// Build option: SYSTOLIC_DESKEW_ZERO_INVALID_EN
//   defined   - the output register is cleared whenever the row being loaded
//               is not valid, so Outputs reads zero while Out_Valid=0.
//   undefined - the output register always loads the lane tails, so stale or
//               partially skewed data stays visible while Out_Valid=0.
module systolic_output_deskew #(
   parameter int DATA_WIDTH = 8,
   parameter int SA_LENGTH  = 5,
   parameter int CNT_WIDTH  = $clog2(SA_LENGTH)
) (
   input  logic                  CLK,
   input  logic                  ASYNC_RST,
   input  logic                  SYNC_RST,
   input  logic                  EN,
   input  logic                  In_Valid,
   input  logic [DATA_WIDTH-1:0] Inputs  [SA_LENGTH],
   output logic [DATA_WIDTH-1:0] Outputs [SA_LENGTH],
   output logic                  Out_Valid,
   output logic [CNT_WIDTH-1:0]  Row_Count,
   output logic                  Tile_Done
);

   localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(SA_LENGTH - 1);

   // Last delay stage of every lane, i.e. what the output register loads next.
   logic [SA_LENGTH-1:0][DATA_WIDTH-1:0] lane_tail;

   // Valid travels alongside lane 0: SA_LENGTH-1 stages here plus Out_Valid.
   logic [SA_LENGTH-2:0] valid_pipe_reg;
   logic                 valid_tail;

   // Index that the next valid row will carry.
   logic [CNT_WIDTH-1:0] row_ptr_reg;
   logic [CNT_WIDTH-1:0] row_ptr_next;

   genvar gi;

   // Per-lane delay lines: lane gi needs SA_LENGTH-1-gi stages ahead of the
   // common output register; the last lane feeds the output register directly.
   for (gi = 0; gi < SA_LENGTH; gi++) begin : g_lane
      localparam int DEPTH = SA_LENGTH - 1 - gi;
      if (DEPTH > 0) begin : g_dly
         logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

         // Shift the lane word one stage per enabled cycle.
         always_ff @(posedge CLK or negedge ASYNC_RST) begin
            if (!ASYNC_RST) begin
               for (int d = 0; d < DEPTH; d++) stage_reg[d] <= '0;
            end else if (SYNC_RST) begin
               for (int d = 0; d < DEPTH; d++) stage_reg[d] <= '0;
            end else if (EN) begin
               stage_reg[0] <= Inputs[gi];
               for (int d = 1; d < DEPTH; d++) stage_reg[d] <= stage_reg[d-1];
            end
         end

         assign lane_tail[gi] = stage_reg[DEPTH-1];
      end else begin : g_direct
         assign lane_tail[gi] = Inputs[gi];
      end
   end

   assign valid_tail   = valid_pipe_reg[SA_LENGTH-2];
   assign row_ptr_next = (row_ptr_reg == LAST_ROW) ? '0 : row_ptr_reg + 1'b1;

   // Valid shift register, same timing as the lane-0 delay line.
   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         valid_pipe_reg <= '0;
      end else if (SYNC_RST) begin
         valid_pipe_reg <= '0;
      end else if (EN) begin
         valid_pipe_reg[0] <= In_Valid;
         for (int d = 1; d < SA_LENGTH - 1; d++) valid_pipe_reg[d] <= valid_pipe_reg[d-1];
      end
   end

   // Output stage: aligned row, valid, row index and tile-done all register together.
   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         for (int l = 0; l < SA_LENGTH; l++) Outputs[l] <= '0;
         Out_Valid   <= 1'b0;
         Row_Count   <= '0;
         Tile_Done   <= 1'b0;
         row_ptr_reg <= '0;
      end else if (SYNC_RST) begin
         for (int l = 0; l < SA_LENGTH; l++) Outputs[l] <= '0;
         Out_Valid   <= 1'b0;
         Row_Count   <= '0;
         Tile_Done   <= 1'b0;
         row_ptr_reg <= '0;
      end else if (EN) begin
`ifdef SYSTOLIC_DESKEW_ZERO_INVALID_EN
         for (int l = 0; l < SA_LENGTH; l++) Outputs[l] <= valid_tail ? lane_tail[l] : '0;
`else
         for (int l = 0; l < SA_LENGTH; l++) Outputs[l] <= lane_tail[l];
`endif
         Out_Valid <= valid_tail;
         Tile_Done <= valid_tail && (row_ptr_reg == LAST_ROW);
         // Invalid rows leave the index untouched so bubbles do not consume a slot.
         if (valid_tail) begin
            Row_Count   <= row_ptr_reg;
            row_ptr_reg <= row_ptr_next;
         end
      end
   end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Bench for systolic_output_deskew (DATA_WIDTH=8, SA_LENGTH=5).
// Stimulus pushes each issued row's expected aligned output into a queue;
// a monitor pops and compares whenever a new valid row is presented.
`timescale 1ns/1ps
module tb_systolic_output_deskew;

   localparam int DW = 8;
   localparam int N  = 5;

   typedef struct packed {
      logic [N-1:0][DW-1:0] data;
      logic [2:0]           cnt;
      logic                 done;
      int                   cyc;
   } exp_t;

   logic          CLK = 1'b0;
   logic          ASYNC_RST = 1'b0;
   logic          SYNC_RST = 1'b0;
   logic          EN = 1'b0;
   logic          In_Valid = 1'b0;
   logic [DW-1:0] lanes_in  [N];
   logic [DW-1:0] lanes_out [N];
   logic          Out_Valid;
   logic [2:0]    Row_Count;
   logic          Tile_Done;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            gcyc     = 0;
   int            model_cnt = 0;
   exp_t          sb_q [$];
   exp_t          mon_e;
   exp_t          last_exp;
   logic          en_q = 1'b0;
   logic [DW-1:0] ring [16][N];

   systolic_output_deskew #(
      .DATA_WIDTH (DW),
      .SA_LENGTH  (N),
      .CNT_WIDTH  (3)
   ) dut (
      .CLK       (CLK),
      .ASYNC_RST (ASYNC_RST),
      .SYNC_RST  (SYNC_RST),
      .EN        (EN),
      .In_Valid  (In_Valid),
      .Inputs    (lanes_in),
      .Outputs   (lanes_out),
      .Out_Valid (Out_Valid),
      .Row_Count (Row_Count),
      .Tile_Done (Tile_Done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      gcyc <= gcyc + 1;
      en_q <= EN;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, gcyc);
      end
   endtask

   // Cycle in which a row issued at local cycle j0 becomes visible: after N enabled edges.
   function automatic int out_cycle(input int start, input int j0, input logic [63:0] stall);
      int cnt = 0;
      for (int jj = j0; jj < j0 + 200; jj++) begin
         if (!(jj < 64 && stall[jj])) begin
            cnt++;
            if (cnt == N) return start + jj + 1;
         end
      end
      return -1;
   endfunction

   // Monitor: a row is new when Out_Valid is set after an enabled edge; held otherwise.
   always @(negedge CLK) begin
      if (ASYNC_RST) begin
         if (Out_Valid && en_q) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_row: Out_Valid=1 but no row pending (cycle %0d)", gcyc);
            end else begin
               mon_e = sb_q.pop_front();
               check("row_cycle", gcyc, mon_e.cyc);
               for (int i = 0; i < N; i++)
                  check($sformatf("row_lane%0d", i), lanes_out[i], mon_e.data[i]);
               check("row_count", Row_Count, mon_e.cnt);
               check("tile_done", Tile_Done, mon_e.done);
               last_exp = mon_e;
               $display("row cycle=%0d count=%0d done=%0d data=%0d,%0d,%0d,%0d,%0d",
                        gcyc, Row_Count, Tile_Done, lanes_out[0], lanes_out[1],
                        lanes_out[2], lanes_out[3], lanes_out[4]);
            end
         end else if (Out_Valid) begin
            for (int i = 0; i < N; i++)
               check($sformatf("hold_lane%0d", i), lanes_out[i], last_exp.data[i]);
            check("hold_count", Row_Count, last_exp.cnt);
            check("hold_done", Tile_Done, last_exp.done);
         end else begin
            check("done_without_valid", Tile_Done, 0);
         end
      end
   end

   // Drive a skewed stream: lane i carries row k at beat k+i. Stalled cycles send junk.
   task automatic run_stream(input int nrows, input logic [31:0] vmask,
                             input logic [63:0] stall, input int base, input int stop_after);
      int   beat = 0;
      int   j = 0;
      int   start = 0;
      int   k;
      exp_t e;
      while (beat < nrows + N + 5 && (stop_after < 0 || j < stop_after)) begin
         @(posedge CLK);
         #1;
         if (j == 0) start = gcyc;
         if (j < 64 && stall[j]) begin
            EN = 1'b0;
            In_Valid = 1'b1;
            for (int i = 0; i < N; i++) lanes_in[i] = 8'($urandom);
         end else begin
            EN = 1'b1;
            In_Valid = (beat < nrows) && vmask[beat];
            for (int i = 0; i < N; i++) begin
               k = beat - i;
               lanes_in[i] = (k >= 0 && k < nrows) ? 8'(base + 10 * k + i) : 8'($urandom);
            end
            if (In_Valid) begin
               for (int i = 0; i < N; i++) e.data[i] = 8'(base + 10 * beat + i);
               e.cnt  = 3'(model_cnt);
               e.done = (model_cnt == N - 1);
               e.cyc  = out_cycle(start, j, stall);
               sb_q.push_back(e);
               model_cnt = (model_cnt + 1) % N;
            end
            beat++;
         end
         j++;
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, Out_Valid, 0);
      check({tag, "_count"}, Row_Count, 0);
      check({tag, "_done"}, Tile_Done, 0);
      for (int i = 0; i < N; i++) check($sformatf("%s_lane%0d", tag, i), lanes_out[i], 0);
   endtask

   // Idle stream with random data: Outputs either zero or the plain delayed lanes.
   task automatic idle_phase();
      for (int j = 0; j < 12; j++) begin
         @(posedge CLK);
         #1;
         EN = 1'b1;
         In_Valid = 1'b0;
         for (int i = 0; i < N; i++) begin
            lanes_in[i] = 8'($urandom);
            ring[gcyc % 16][i] = lanes_in[i];
         end
         @(negedge CLK);
         if (j >= 5) begin
            check("idle_valid", Out_Valid, 0);
            for (int i = 0; i < N; i++) begin
`ifdef SYSTOLIC_DESKEW_ZERO_INVALID_EN
               check($sformatf("idle_lane%0d", i), lanes_out[i], 0);
`else
               check($sformatf("idle_lane%0d", i), lanes_out[i], ring[(gcyc - 5 + i) % 16][i]);
`endif
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) lanes_in[i] = '0;
      #1;
      check_cleared("async_reset");
      #1 ASYNC_RST = 1'b1;

      // Single tile after reset
      run_stream(5, 32'hFFFF_FFFF, 64'h0, 0, -1);
      // Stall at cycles 3..4 before any output appears
      run_stream(5, 32'hFFFF_FFFF, 64'h18, 100, -1);
      // Back-to-back tiles, with a stall while rows are on the output
      run_stream(10, 32'hFFFF_FFFF, 64'h180, 0, -1);
      // Bubble in row slot 2
      run_stream(5, 32'h0000_001B, 64'h0, 150, -1);

      // Synchronous reset after three rows, with EN low to show it wins
      run_stream(3, 32'hFFFF_FFFF, 64'h0, 50, 3);
      @(posedge CLK);
      #1;
      SYNC_RST = 1'b1;
      EN = 1'b0;
      In_Valid = 1'b1;
      for (int i = 0; i < N; i++) lanes_in[i] = 8'($urandom);
      sb_q.delete();
      model_cnt = 0;
      @(posedge CLK);
      @(negedge CLK);
      check_cleared("sync_reset");
      SYNC_RST = 1'b0;
      EN = 1'b1;
      In_Valid = 1'b0;
      run_stream(5, 32'hFFFF_FFFF, 64'h0, 20, -1);

      // Invalid-cycle output content
      idle_phase();

      // Asynchronous reset mid-stream, away from any clock edge
      run_stream(5, 32'hFFFF_FFFF, 64'h0, 70, 7);
      @(posedge CLK);
      #2 ASYNC_RST = 1'b0;
      sb_q.delete();
      model_cnt = 0;
      #1;
      check_cleared("async_midstream");
      @(negedge CLK);
      #1 ASYNC_RST = 1'b1;
      run_stream(5, 32'hFFFF_FFFF, 64'h0, 30, -1);

      @(negedge CLK);
      check("rows_outstanding", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_output_deskew.md
Name: systolic_output_deskew

Overview:
- Receive end of the systolic skew protocol: accepts the diagonally skewed result stream leaving the systolic array. In that stream, lane i carries element k at cycle t0+k+i.
- Re-aligns the lanes so each output row is presented on one cycle with a valid strobe.
- Tracks row position inside an SA_LENGTH-row tile and pulses a tile-done flag.
- Sits between the array's output edge and the result buffer; mirror of the input skew stage.

Parameters:
- DATA_WIDTH, 8: width of each lane word.
- SA_LENGTH, 5: number of lanes, equal to the array dimension; must be ≥2.
- CNT_WIDTH, $clog2(SA_LENGTH): width of Row_Count.

Ports:
- CLK  input  1  clock, rising edge.
- ASYNC_RST  input  1  asynchronous, active-low reset.
- SYNC_RST  input  1  synchronous reset, active-high; sampled on CLK.
- EN  input  1  global advance enable; 0 freezes all state.
- In_Valid  input  1  qualifies the lane-0 word of a row (row k's lane-0 element arrives at t0+k).
- Inputs  input  [DATA_WIDTH-1:0] x SA_LENGTH (unpacked)  skewed lane data from the array.
- Outputs  output  [DATA_WIDTH-1:0] x SA_LENGTH (unpacked)  de-skewed, row-aligned data.
- Out_Valid  output  1  Outputs holds a complete aligned row.
- Row_Count  output  CNT_WIDTH  index of the row currently on Outputs; range 0..SA_LENGTH-1.
- Tile_Done  output  1  high together with the row whose Row_Count = SA_LENGTH-1.

Behaviour:
- Reset (ASYNC_RST=0, immediate): all delay-line stages, Outputs, Out_Valid, Row_Count and Tile_Done are 0.
- SYNC_RST=1 at a rising edge gives the same cleared state. SYNC_RST has priority over EN.
- Lane i delay line:
  - SA_LENGTH-1-i register stages, followed by one common output register.
  - Total latency of lane i is SA_LENGTH-i cycles.
  - Lane SA_LENGTH-1 has only the output register (1 cycle).
- Valid path: In_Valid passes through a SA_LENGTH-deep shift register to produce Out_Valid. Element k of every lane therefore appears on Outputs at t0+k+SA_LENGTH, with Out_Valid=1.
- EN=0:
  - No register changes: delay lines, valid pipe and counter all hold.
  - Outputs, Out_Valid, Row_Count and Tile_Done keep their values.
  - In_Valid and Inputs are ignored that cycle. The upstream array stalls on the same EN.
- Row counter:
  - Increments on each cycle where the output stage loads a valid row (EN=1 and the valid pipe tail=1).
  - Wraps from SA_LENGTH-1 to 0.
  - Row_Count is registered alongside Outputs and shows the index of the row on Outputs.
- Tile_Done = Out_Valid && Row_Count==SA_LENGTH-1, registered with Outputs. It is a single-cycle pulse unless EN holds it.
- Bubbles: In_Valid gaps propagate as Out_Valid gaps. The row counter does not advance on invalid rows.
- Back-to-back tiles with no gap:
  - Row_Count runs 0..SA_LENGTH-1, then 0 again.
  - Tile_Done fires once per tile.
- Reset mid-stream: all in-flight rows are discarded, the counter returns to 0, and no partial-row valid is produced afterwards.
- Stream tail: the producer drains by feeding SA_LENGTH-1 cycles of In_Valid=0 while lanes 1..SA_LENGTH-1 still carry data. The de-skew stage has no drain logic of its own.

Optional Feature:
- Macro: SYSTOLIC_DESKEW_ZERO_INVALID_EN.
- Defined: Outputs is forced to all-zero on any cycle where Out_Valid=0. This is implemented as a clear of the output register when the valid pipe tail is 0.
- Undefined: Outputs always shows the output register content, including stale or partially skewed data, while Out_Valid=0. This saves the clear mux.
- Valid, count and done behaviour is identical in both builds.

Test Plan (DATA_WIDTH=8, SA_LENGTH=5):
1. Reset-then-single-tile:
   - Stimulus: ASYNC_RST low 2 ns then high, EN=1. Drive lane i with value 10*k+i at cycle k+i for k=0..4, with In_Valid high at cycles 0..4.
   - Required: at cycles 5..9, Outputs = {10k,10k+1,…,10k+4}, Out_Valid=1 and Row_Count=k. Tile_Done=1 only at cycle 9.
2. EN stall:
   - Stimulus: scenario 1 with EN=0 for cycles 3..4.
   - Required: every output event shifts by exactly 2 cycles. Outputs and flags hold steady during the stall.
3. Back-to-back tiles:
   - Stimulus: 10 consecutive valid rows.
   - Required: Row_Count sequence 0,1,2,3,4,0,1,2,3,4, with Tile_Done at the 5th and 10th rows.
4. Bubble:
   - Stimulus: In_Valid=0 for row slot 2.
   - Required: Out_Valid=0 at the matching output cycle, and the next valid row still reports Row_Count=2.
5. SYNC_RST mid-tile:
   - Stimulus: pulse SYNC_RST after 3 valid rows.
   - Required: the next edge clears all outputs to 0. Out_Valid stays 0 until a new row completes SA_LENGTH cycles later, and Row_Count restarts at 0.
6. Macro check:
   - Stimulus: random data with In_Valid=0.
   - Required: with SYSTOLIC_DESKEW_ZERO_INVALID_EN, Outputs==0 on all invalid cycles. Without it, Outputs shows the delayed lane values.
